truth_table_checker: RTL and testbench

Self-checking response monitor for a 3-input combinational block under test. On `start` it sweeps {a,b,c} through all eight input combinations in ascending order and holds each vector for a fixed dwell. At the end of each dwell it samples the DUT output `f_in` and assembles an observed 8-entry truth table. It then compares that table against a supplied expected table and reports pass/fail, the mismatch mask, the mismatch count and the first failing index. It sits alongside the DUT in the lab bring-up design and replaces manual waveform inspection of exhaustive stimulus.

---
 rtl/tt_pkg.sv | 15 +
 rtl/dwell_counter.sv | 28 ++
 rtl/truth_table_checker.sv | 130 +++++++++++++
 tb/tb_truth_table_checker.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared types and widths for the truth table checker
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 8;
  localparam int IDX_W       = 3;
  localparam int CNT_W       = 16;
  localparam int FAILCNT_W   = 4;

endpackage

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - free-running dwell counter with terminal tick and auto-reload
module dwell_counter #(
  parameter int DWELL = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  import tt_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == LAST);

  // Count enabled cycles, reloading to zero on the terminal count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - exhaustive 3-input sweep monitor with truth table compare
module truth_table_checker
  import tt_pkg::*;
#(
  parameter int DWELL = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       f_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] observed,
  output logic [7:0] mismatch,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  state_t               state;
  state_t               state_next;
  logic [IDX_W-1:0]     idx;
  logic [7:0]           exp_q;
  logic                 tick;
  logic                 cnt_en;
  logic                 cnt_clear;
  logic [7:0]           obs_final;
  logic [7:0]           mism_final;
  logic [FAILCNT_W-1:0] fcnt_final;
  logic [IDX_W-1:0]     ffi_final;

  assign cnt_en    = (state == RUN);
  assign cnt_clear = (state != RUN);

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .tick   (tick)
  );

  // Stimulus is only driven during the sweep; 000 otherwise.
  assign {a_out, b_out, c_out} = (state == RUN) ? idx : '0;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start only honoured in IDLE, DONE lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (tick && (idx == LAST_IDX)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Table including the sample being taken this cycle, its compare, popcount and lowest failing index.
  always_comb begin
    obs_final      = observed;
    obs_final[idx] = f_in;
    mism_final     = obs_final ^ exp_q;
    fcnt_final     = '0;
    ffi_final      = '0;
    for (int i = 0; i < NUM_VECTORS; i++) begin
      fcnt_final = fcnt_final + FAILCNT_W'(mism_final[i]);
    end
    for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
      if (mism_final[i]) ffi_final = IDX_W'(i);
    end
  end

  // Sweep datapath: latch expectation on accept, sample at dwell end, register results entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx            <= '0;
      exp_q          <= '0;
      observed       <= '0;
      mismatch       <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      pass           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_q          <= expected;
            idx            <= '0;
            observed       <= '0;
            mismatch       <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
          end
        end
        RUN: begin
          if (tick) begin
            observed <= obs_final;
            if (idx == LAST_IDX) begin
              mismatch       <= mism_final;
              fail_count     <= fcnt_final;
              first_fail_idx <= ffi_final;
              pass           <= (mism_final == 8'h00);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - directed table-driven bench for truth_table_checker
module tb_truth_table_checker;

  localparam int DWELL = 4;

  typedef struct {
    int         mode;
    logic [7:0] exp_in;
    logic [7:0] obs;
    logic [7:0] mism;
    logic [3:0] fcnt;
    logic [2:0] ffi;
    logic       pas;
    bit         mid;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] expected;
  logic       f_in;
  logic       a_out, b_out, c_out;
  logic       busy, done, pass;
  logic [7:0] observed, mismatch;
  logic [3:0] fail_count;
  logic [2:0] first_fail_idx;

  int mode;
  int checks = 0;
  int errors = 0;
  vec_t vecs[6];

  truth_table_checker #(.DWELL(DWELL)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .expected       (expected),
    .f_in           (f_in),
    .a_out          (a_out),
    .b_out          (b_out),
    .c_out          (c_out),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .observed       (observed),
    .mismatch       (mismatch),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx)
  );

  always #5 clk = ~clk;

  // Behavioural block under test: 0 = XOR3, 1 = AND3, 2 = constant 0.
  always_comb begin
    f_in = 1'b0;
    case (mode)
      0: f_in = a_out ^ b_out ^ c_out;
      1: f_in = a_out & b_out & c_out;
      default: f_in = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_abc"},  {a_out, b_out, c_out}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_obs"},  observed, 0);
    chk({tag, "_mism"}, mismatch, 0);
    chk({tag, "_fcnt"}, fail_count, 0);
    chk({tag, "_ffi"},  first_fail_idx, 0);
  endtask

  task automatic run_sweep(input vec_t v);
    mode     = v.mode;
    expected = v.exp_in;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("clr_obs",  observed, 0);
    chk("clr_mism", mismatch, 0);
    chk("clr_fcnt", fail_count, 0);
    chk("clr_ffi",  first_fail_idx, 0);
    chk("clr_pass", pass, 0);
    for (int t = 0; t < 8 * DWELL; t++) begin
      chk("stim", {a_out, b_out, c_out}, t / DWELL);
      chk("busy_run", busy, 1);
      chk("done_early", done, 0);
      start = v.mid && (t == 5 || t == 20);
      if (v.mid && t == 10) expected = ~v.exp_in;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    chk("stim_done", {a_out, b_out, c_out}, 0);
    chk("observed", observed, v.obs);
    chk("mismatch", mismatch, v.mism);
    chk("fail_count", fail_count, v.fcnt);
    chk("first_fail_idx", first_fail_idx, v.ffi);
    chk("pass", pass, v.pas);
    @(posedge clk); #1;
    chk("done_once", done, 0);
    chk("busy_idle", busy, 0);
    chk("stim_idle", {a_out, b_out, c_out}, 0);
    chk("hold_obs", observed, v.obs);
    chk("hold_pass", pass, v.pas);
  endtask

  task automatic reset_mid_sweep();
    mode     = 0;
    expected = 8'h96;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all_zero("midrst");
    for (int t = 0; t < 10 * DWELL; t++) begin
      chk("no_done_after_rst", done, 0);
      chk("idle_after_rst", busy, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vecs[0] = '{0, 8'h96, 8'h96, 8'h00, 4'd0, 3'd0, 1'b1, 1'b0};
    vecs[1] = '{1, 8'hE8, 8'h80, 8'h68, 4'd3, 3'd3, 1'b0, 1'b0};
    vecs[2] = '{2, 8'hFF, 8'h00, 8'hFF, 4'd8, 3'd0, 1'b0, 1'b0};
    vecs[3] = '{0, 8'h96, 8'h96, 8'h00, 4'd0, 3'd0, 1'b1, 1'b1};
    vecs[4] = '{0, 8'h96, 8'h96, 8'h00, 4'd0, 3'd0, 1'b1, 1'b0};
    vecs[5] = '{1, 8'hA0, 8'h80, 8'h20, 4'd1, 3'd5, 1'b0, 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    expected = 8'h00;
    mode     = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("post_reset");

    for (int i = 0; i < 6; i++) begin
      if (i == 4) reset_mid_sweep();
      run_sweep(vecs[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
